// File: rtl/mport_ram_pkg.sv
// Shared definitions for the multi-read byte-strobed RAM (mport_byte_ram):
// init/run state encoding, default geometry and small slicing/merge helpers.
package mport_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_t;

  localparam int DEF_DW      = 32;
  localparam int DEF_AW      = 12;
  localparam int DEF_MEM_NUM = 4096;
  localparam int DEF_NRD     = 2;
  localparam int NB          = DEF_DW / 8;

  // LSB position of port k inside a packed bus of w-bit ports.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

  // One byte lane of the read/forward merge: take the new byte when selected.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       sel);
    return sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mport_ram_rdport.sv
// One read port of mport_byte_ram: registers the addressed memory word, the
// byte mask of a same-cycle write hit and that write's data, then merges
// them per byte so read-during-write returns the freshly written bytes.
module mport_ram_rdport
  import mport_ram_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ren,
  input  logic [DW-1:0]   i_rd_word,
  input  logic [DW/8-1:0] i_fwd_mask,
  input  logic [DW-1:0]   i_wdata,
  output logic [DW-1:0]   o_rdata
);

  localparam int NBL = DW / 8;

  logic [DW-1:0]  r_word;
  logic [DW-1:0]  r_wdata;
  logic [NBL-1:0] r_mask;

  // Capture word, forward mask and write data on a read; hold otherwise.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else if (i_ren) begin
      r_word  <= i_rd_word;
      r_wdata <= i_wdata;
      r_mask  <= i_fwd_mask;
    end
  end

  for (genvar b = 0; b < NBL; b++) begin : g_byte
    assign o_rdata[8*b +: 8] = merge_byte(r_word[8*b +: 8], r_wdata[8*b +: 8], r_mask[b]);
  end

endmodule

// File: rtl/mport_byte_ram.sv
// Single-write, multi-read synchronous RAM with per-byte write strobes and
// byte-merged read-during-write forwarding on every read port.
// Optional clear sequencer: define MPORT_RAM_INIT_EN to zero the array after
// reset (init_busy_o high meanwhile); undefined, the block runs immediately.
module mport_byte_ram
  import mport_ram_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int MEM_NUM = DEF_MEM_NUM,
  parameter int NRD     = DEF_NRD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [DW/8-1:0]   wstrb_i,
  input  logic [AW-1:0]     w_addr_i,
  input  logic [DW-1:0]     w_data_i,
  input  logic [NRD-1:0]    ren,
  input  logic [NRD*AW-1:0] r_addr_i,
  output logic [NRD*DW-1:0] r_data_o,
  output logic              init_busy_o
);

  localparam int NBL = DW / 8;

  logic [DW-1:0] r_mem [MEM_NUM];

  logic          w_run;
  logic          w_clr;
  logic [AW-1:0] w_clr_addr;
  logic          w_wr_ok;

`ifdef MPORT_RAM_INIT_EN
  ram_state_t    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  // Clear sequencer: walk every word once after reset, then stay in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(MEM_NUM - 1)) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b0;
      end
    end
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_clr       = rst && (r_state == ST_INIT);
  assign w_clr_addr  = r_cnt;
  assign init_busy_o = r_busy;
`else
  assign w_run       = 1'b1;
  assign w_clr       = 1'b0;
  assign w_clr_addr  = '0;
  assign init_busy_o = 1'b0;
`endif

  // Out-of-range writes are dropped rather than aliased onto a real word.
  assign w_wr_ok = w_run && wen && (32'(w_addr_i) < MEM_NUM);

  // Array update: clear sequencer has priority, else strobed external write.
  // NOTE: the array is deliberately not reset; only the clear sequencer
  // zeroes it, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      for (int b = 0; b < NBL; b++) begin
        if (wstrb_i[b]) r_mem[w_addr_i][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]  w_raddr;
    logic           w_rvalid;
    logic [DW-1:0]  w_rword;
    logic [NBL-1:0] w_fwd;

    assign w_raddr  = r_addr_i[port_lsb(k, AW) +: AW];
    // Reads while clearing or beyond the array load zero and never forward.
    assign w_rvalid = w_run && (32'(w_raddr) < MEM_NUM);
    assign w_rword  = w_rvalid ? r_mem[w_raddr] : '0;
    assign w_fwd    = (w_rvalid && w_wr_ok && (w_addr_i == w_raddr)) ? wstrb_i : '0;

    mport_ram_rdport #(.DW(DW)) u_rdport (
      .clk        (clk),
      .rst        (rst),
      .i_ren      (ren[k]),
      .i_rd_word  (w_rword),
      .i_fwd_mask (w_fwd),
      .i_wdata    (w_data_i),
      .o_rdata    (r_data_o[port_lsb(k, DW) +: DW])
    );
  end

endmodule

// File: doc/mport_byte_ram.md
# mport_byte_ram

Single-write, multi-read synchronous RAM with per-byte write strobes. Read-during-write to the same address returns the new data, merged byte by byte. An optional clear sequencer zeroes the whole array after reset. It is the next generation of the CPU's dual-port RAM and serves as the shared data/register-file store when more than one pipeline stage reads in the same cycle.

## Interface
- DW, 32: data width; must be a multiple of 8.
- AW, 12: address width.
- MEM_NUM, 4096: number of words; must be ≤ 2**AW.
- NRD, 2: number of independent read ports, 1..4.
- clk  in  1: clock; all state changes on its rising edge.
- rst  in  1: reset, synchronous, active-low.
- wen  in  1: write enable.
- wstrb_i  in  DW/8: byte write strobes; bit b covers w_data_i[8b+7:8b].
- w_addr_i  in  AW: write address.
- w_data_i  in  DW: write data.
- ren  in  NRD: per-port read enable.
- r_addr_i  in  NRD*AW: packed read addresses; port k at [k*AW +: AW].
- r_data_o  out  NRD*DW: packed read data; port k at [k*DW +: DW].
- init_busy_o  out  1: high while the clear sequencer owns the array.

## Operation
- Write: when wen=1 and the block is in RUN, only bytes with wstrb_i[b]=1 are stored at w_addr_i. wstrb_i=0 is a no-op write. A write with w_addr_i ≥ MEM_NUM is dropped.
- Read port k:
  - When ren[k]=1, the port samples mem[r_addr_i[k]].
  - When ren[k]=0, the port holds its previous r_data_o value, including any forwarded bytes.
  - A read with r_addr_i[k] ≥ MEM_NUM returns 0.
- Collision handling:
  - Condition: wen=1, ren[k]=1 and w_addr_i == r_addr_i[k] in the same cycle.
  - Result for port k: bytes with wstrb_i[b]=1 come from w_data_i; the other bytes come from the old memory word.
  - Implementation: per port, register a DW/8 forward mask and w_data_i when ren[k]=1. Mux per byte at the output.
  - Every port collides independently.
- Init FSM, states INIT and RUN:
  - rst=0 → INIT, clear counter = 0.
  - In INIT: write 0 to mem[counter], all bytes, then counter+1. When counter == MEM_NUM-1, the next state is RUN.
  - While in INIT: external writes are ignored, reads with ren[k]=1 load 0, and init_busy_o=1.
  - RUN is terminal until the next rst=0.

## Timing
- Read latency 1 cycle: r_addr_i sampled at edge N, data visible after edge N.
- Write latency 1 cycle: a read at edge N+1 of an address written at edge N sees the new data.
- Reset values: r_data_o = 0, all forward masks = 0, init_busy_o = 1 (= 0 when the macro is off), FSM = INIT.
- INIT lasts exactly MEM_NUM cycles after the first edge with rst=1. init_busy_o falls after edge MEM_NUM.
- Reset asserted mid-INIT restarts the counter at 0. Reset asserted in RUN re-enters INIT. Memory contents are not otherwise touched by reset.
- Simultaneous collision and ren[k]=0: no forwarding; the port holds its value.

## Configuration
- MPORT_RAM_INIT_EN defined:
  - The clear sequencer is compiled in.
  - After reset the array is all zeros.
  - Timing is as above.
- MPORT_RAM_INIT_EN undefined:
  - No FSM and no counter.
  - init_busy_o is tied to 0 and the block is in RUN from the first edge after reset.
  - Memory contents are X until written.

## Structure
- Package mport_ram_pkg holds:
  - The INIT/RUN state encoding.
  - Localparam NB = DW/8.
  - Helper functions for packed-port slicing and per-byte merge.
- Sub-module mport_ram_rdport, instantiated NRD times in a generate loop. It holds the registered memory word, the forward mask, the registered write data and the byte-merge output mux.
- The top level holds the memory array, the write/strobe logic and the init FSM.

## Test plan
- Reset then idle, macro on:
  - Expected: init_busy_o=1 for exactly MEM_NUM cycles.
  - Then read addresses 0, 5 and MEM_NUM-1 on both ports → 0x00000000.
- Partial write:
  - Write 0xAABBCCDD, strb 0xF, to addr 3.
  - Then write 0x11223344, strb 0x5, to addr 3.
  - Read addr 3 → 0xAA22CC44.
- Collision merge:
  - mem[7]=0x12345678. Same cycle: write 0xDEADBEEF, strb 0x3, addr 7, with ren[0]=1, addr 7.
  - Port 0 → 0x1234BEEF.
  - The next read of addr 7 → 0x1234BEEF.
- Multi-port: port 0 reads addr 3 while port 1 reads addr 7 in the same cycle → both ports return correct independent data.
- Hold and forward retention:
  - After the collision above, drop ren[0] for 3 cycles while writing 0 to addr 7.
  - Port 0 stays 0x1234BEEF.
- Reset mid-INIT and illegal address:
  - Assert rst=0 at clear count 100 → counter restarts at 0 and busy lasts MEM_NUM cycles again.
  - In RUN, write to addr MEM_NUM → no memory change; a read of addr MEM_NUM → 0.
